fetch_unit: RTL

//  Instruction-fetch stage. Owns the PC, issues single-outstanding requests to instruction memory,
//  and presents {instr, pc, valid} to the IF/ID pipeline register under downstream stall.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_skid.sv | 35 +++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: canonical NOP encoding and the fetch FSM state enum.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_TRAP
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry {instr, pc} holding register used when a response lands while the output slot is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, single outstanding imem request, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap state.
//
// state  | meaning
// S_REQ  | issue fetch at pc when the output slot can take a result
// S_WAIT | request accepted, waiting for its response
// S_HOLD | response parked in skid, waiting for downstream to consume
// S_DROP | redirect hit an in-flight request; discard its response
// S_TRAP | misaligned redirect target reported, fetch halted until next redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_valid,
  output logic [31:0]        fetch_instr,
  output logic [31:0]        fetch_pc,
  output logic               fetch_misalign
);
  import riscv_pipe_pkg::fetch_state_t;
  import riscv_pipe_pkg::S_REQ;
  import riscv_pipe_pkg::S_WAIT;
  import riscv_pipe_pkg::S_HOLD;
  import riscv_pipe_pkg::S_DROP;
  import riscv_pipe_pkg::S_TRAP;
  import riscv_pipe_pkg::pc_plus4;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  opc_q, opc_d;
  logic         mis_q, mis_d;

  logic         consume, slot_free, req_fire, loaded;
  logic         skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0]  skid_instr, skid_pc;
  logic [31:0]  redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_target = redirect_pc;
`else
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign consume   = valid_q && !stall;
  assign slot_free = !valid_q || consume;

  assign imem.imem_req_valid = !rst && (state_q == S_REQ) && slot_free;
  assign imem.imem_req_addr  = pc_q;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (skid_flush),
    .load_instr (imem.imem_resp_data),
    .load_pc    (pc_q),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    opc_d       = opc_q;
    mis_d       = mis_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;
    loaded      = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over stall: the output slot is flushed unconditionally.
      skid_flush = 1'b1;
      pc_d       = redir_target;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      opc_d      = '0;
      mis_d      = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem.imem_resp_valid ? S_REQ : S_DROP;
        S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
        S_DROP:  state_d = imem.imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = S_TRAP;
        valid_d = 1'b1;
        opc_d   = redirect_pc;
        mis_d   = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            pc_d = pc_plus4(pc_q);
            if (slot_free) begin
              loaded  = 1'b1;
              valid_d = 1'b1;
              instr_d = imem.imem_resp_data;
              opc_d   = pc_q;
              state_d = S_REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume && skid_full) begin
            loaded      = 1'b1;
            skid_unload = 1'b1;
            valid_d     = 1'b1;
            instr_d     = skid_instr;
            opc_d       = skid_pc;
            state_d     = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_resp_valid) state_d = S_REQ;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          state_d = S_TRAP;
        end
`endif
        default: state_d = S_REQ;
      endcase

      if (!loaded && consume && (state_q != S_TRAP)) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        opc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      opc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      mis_q   <= mis_d;
    end
  end

  assign fetch_valid    = valid_q;
  assign fetch_instr    = instr_q;
  assign fetch_pc       = opc_q;
  assign fetch_misalign = mis_q;

endmodule
